// File: rtl/scr1_tapc_tck_oversampler.sv
// JTAG front end: synchronises raw TCK and channel pins into clk, filters TCK
// glitches and emits one-cycle rise/fall strobes with captured channel data.
//
// state    | meaning
// ST_PRIME | waiting for FILT_LEN equal valid TCK samples to seed the filtered level
// ST_RUN   | filter primed; accepted toggles produce strobes and gap checks
module scr1_tapc_tck_oversampler #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 2,
  parameter int RISE_W      = 4,
  parameter int FALL_W      = 1,
  parameter int MIN_GAP     = 3,
  parameter int CNT_W       = 8,
  parameter int HOLD_DATA   = 0
) (
  input  logic              clk,
  input  logic              pwrup_rst_n,
  input  logic              en_i,
  input  logic              tck_i,
  input  logic [RISE_W-1:0] rise_ch_i,
  input  logic [FALL_W-1:0] fall_ch_i,
  input  logic              err_clr_i,
  output logic              tck_filt_o,
  output logic              rise_vld_o,
  output logic [RISE_W-1:0] rise_data_o,
  output logic              fall_vld_o,
  output logic [FALL_W-1:0] fall_data_o,
  output logic [CNT_W-1:0]  rise_cnt_o,
  output logic              overrun_o
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int GW = $clog2(MIN_GAP + 1);

  typedef enum logic {ST_PRIME = 1'b0, ST_RUN = 1'b1} state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0]             r_tck_sync;
  logic [SYNC_STAGES-1:0]             r_vld_sync;
  logic [SYNC_STAGES-1:0][RISE_W-1:0] r_rise_sync;
  logic [SYNC_STAGES-1:0][FALL_W-1:0] r_fall_sync;

  logic              r_tck_filt, w_filt_nxt;
  logic              r_cand;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [GW-1:0]     r_gap, w_gap_nxt;
  logic              r_rise_vld, r_fall_vld, r_overrun;
  logic [RISE_W-1:0] r_rise_data;
  logic [FALL_W-1:0] r_fall_data;
  logic [CNT_W-1:0]  r_rise_cnt;

  logic              w_tck_s, w_samp_vld;
  logic [RISE_W-1:0] w_rise_s;
  logic [FALL_W-1:0] w_fall_s;
  logic              w_toggle, w_prime_load, w_ovr_set, w_rise, w_fall;

  assign w_tck_s    = r_tck_sync[SYNC_STAGES-1];
  assign w_samp_vld = r_vld_sync[SYNC_STAGES-1];
  assign w_rise_s   = r_rise_sync[SYNC_STAGES-1];
  assign w_fall_s   = r_fall_sync[SYNC_STAGES-1];

  // r_vld_sync marks when the TCK chain holds real samples rather than reset zeros,
  // so a TCK held high through reset primes high instead of producing a rise.
  always_ff @(posedge clk or negedge pwrup_rst_n) begin
    if (!pwrup_rst_n) begin
      r_tck_sync  <= '0;
      r_vld_sync  <= '0;
      r_rise_sync <= '0;
      r_fall_sync <= '0;
    end else begin
      r_tck_sync  <= {r_tck_sync[SYNC_STAGES-2:0], tck_i};
      r_vld_sync  <= {r_vld_sync[SYNC_STAGES-2:0], 1'b1};
      r_rise_sync <= {r_rise_sync[SYNC_STAGES-2:0], rise_ch_i};
      r_fall_sync <= {r_fall_sync[SYNC_STAGES-2:0], fall_ch_i};
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_filt_nxt   = r_tck_filt;
    w_cnt_nxt    = r_cnt;
    w_toggle     = 1'b0;
    w_prime_load = 1'b0;
    case (r_state)
      ST_PRIME: begin
        // r_cnt counts equal samples seen so far; 0 means no run started yet
        if (w_samp_vld) begin
          if ((r_cnt == '0) || (w_tck_s == r_cand)) begin
            if (r_cnt == CW'(FILT_LEN - 1)) begin
              w_prime_load = 1'b1;
              w_filt_nxt   = w_tck_s;
              w_cnt_nxt    = '0;
              w_state_nxt  = ST_RUN;
            end else begin
              w_cnt_nxt = r_cnt + CW'(1);
            end
          end else begin
            w_cnt_nxt = CW'(1);
          end
        end
      end
      ST_RUN: begin
        if (w_tck_s == r_tck_filt) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == CW'(FILT_LEN - 1)) begin
          w_toggle   = 1'b1;
          w_filt_nxt = ~r_tck_filt;
          w_cnt_nxt  = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = ST_PRIME;
    endcase
  end

  always_comb begin
    w_gap_nxt = r_gap;
    if (w_toggle || w_prime_load) begin
      w_gap_nxt = '0;
    end else if (r_gap != GW'(MIN_GAP)) begin
      w_gap_nxt = r_gap + GW'(1);
    end
  end

  assign w_ovr_set = w_toggle && ((int'(r_gap) + 1) < MIN_GAP);
  assign w_rise    = w_toggle && !r_tck_filt && en_i;
  assign w_fall    = w_toggle &&  r_tck_filt && en_i;

  always_ff @(posedge clk or negedge pwrup_rst_n) begin
    if (!pwrup_rst_n) begin
      r_state     <= ST_PRIME;
      r_tck_filt  <= 1'b0;
      r_cand      <= 1'b0;
      r_cnt       <= '0;
      r_gap       <= '0;
      r_rise_vld  <= 1'b0;
      r_fall_vld  <= 1'b0;
      r_rise_data <= '0;
      r_fall_data <= '0;
      r_rise_cnt  <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tck_filt <= w_filt_nxt;
      r_cand     <= w_tck_s;
      r_cnt      <= w_cnt_nxt;
      r_gap      <= w_gap_nxt;
      r_rise_vld <= w_rise;
      r_fall_vld <= w_fall;
      if (w_rise) begin
        r_rise_data <= w_rise_s;
        r_rise_cnt  <= r_rise_cnt + CNT_W'(1);
      end else if (HOLD_DATA == 0) begin
        r_rise_data <= '0;
      end
      if (w_fall) begin
        r_fall_data <= w_fall_s;
      end else if (HOLD_DATA == 0) begin
        r_fall_data <= '0;
      end
      // a new violation wins over a coincident clear
      r_overrun <= w_ovr_set | (r_overrun & ~err_clr_i);
    end
  end

  assign tck_filt_o  = r_tck_filt;
  assign rise_vld_o  = r_rise_vld;
  assign rise_data_o = r_rise_data;
  assign fall_vld_o  = r_fall_vld;
  assign fall_data_o = r_fall_data;
  assign rise_cnt_o  = r_rise_cnt;
  assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_scr1_tapc_tck_oversampler.sv
// Bench for scr1_tapc_tck_oversampler: directed and randomized TCK/channel
// stimulus against a sample-window reference model, HOLD_DATA 0 and 1 instances.
module tb_scr1_tapc_tck_oversampler;
  localparam int SYNC = 2;
  localparam int FILT = 2;
  localparam int GAP  = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, tck, clr;
  logic [3:0] rch;
  logic [0:0] fch;

  logic       filt0, rvld0, fvld0, ovr0, filt1, rvld1, fvld1, ovr1;
  logic [3:0] rdata0, rdata1;
  logic [0:0] fdata0, fdata1;
  logic [7:0] cnt0, cnt1;

  scr1_tapc_tck_oversampler u_dut (
    .clk(clk), .pwrup_rst_n(rst_n), .en_i(en), .tck_i(tck), .rise_ch_i(rch),
    .fall_ch_i(fch), .err_clr_i(clr), .tck_filt_o(filt0), .rise_vld_o(rvld0),
    .rise_data_o(rdata0), .fall_vld_o(fvld0), .fall_data_o(fdata0),
    .rise_cnt_o(cnt0), .overrun_o(ovr0));

  scr1_tapc_tck_oversampler #(.HOLD_DATA(1)) u_dut_hold (
    .clk(clk), .pwrup_rst_n(rst_n), .en_i(en), .tck_i(tck), .rise_ch_i(rch),
    .fall_ch_i(fch), .err_clr_i(clr), .tck_filt_o(filt1), .rise_vld_o(rvld1),
    .rise_data_o(rdata1), .fall_vld_o(fvld1), .fall_data_o(fdata1),
    .rise_cnt_o(cnt1), .overrun_o(ovr1));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: history of pin samples, filter decided over sample windows
  bit         q_tck[$];
  logic [3:0] q_rch[$];
  logic       q_fch[$];
  int         m_n, m_last;
  bit         m_primed, m_filt, m_rvld, m_fvld, m_ovr;
  logic [3:0] m_rd0, m_rd1;
  logic       m_fd0, m_fd1;
  logic [7:0] m_cnt;

  task automatic model_reset();
    q_tck.delete(); q_rch.delete(); q_fch.delete();
    m_n = 0; m_last = 0; m_primed = 0; m_filt = 0; m_rvld = 0; m_fvld = 0;
    m_ovr = 0; m_rd0 = 0; m_rd1 = 0; m_fd0 = 0; m_fd1 = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit t, input logic [3:0] r, input logic f,
                            input bit e, input bit c);
    bit tog, set, same;
    int nv;
    tog = 0; set = 0;
    q_tck.push_back(t); q_rch.push_back(r); q_fch.push_back(f);
    m_n++;
    nv = m_n - SYNC;  // samples that have reached the filter, newest at nv-1
    if (!m_primed) begin
      if (nv >= FILT) begin
        same = 1;
        for (int k = 1; k < FILT; k++) if (q_tck[nv-1-k] != q_tck[nv-1]) same = 0;
        if (same) begin
          m_primed = 1; m_filt = q_tck[nv-1]; m_last = m_n;
        end
      end
    end else begin
      same = 0;
      for (int k = 0; k < FILT; k++) if (q_tck[nv-1-k] == m_filt) same = 1;
      if (!same) begin
        tog = 1; set = (m_n - m_last) < GAP; m_last = m_n; m_filt = !m_filt;
      end
    end
    m_rvld = tog && m_filt && e;
    m_fvld = tog && !m_filt && e;
    if (m_rvld) begin
      m_rd0 = q_rch[nv-1]; m_rd1 = q_rch[nv-1]; m_cnt = m_cnt + 8'd1;
    end else m_rd0 = 0;
    if (m_fvld) begin
      m_fd0 = q_fch[nv-1]; m_fd1 = q_fch[nv-1];
    end else m_fd0 = 0;
    m_ovr = set || (m_ovr && !c);
  endtask

  logic [7:0] prev_cnt = 0;
  bit         saw_wrap = 0;

  task automatic compare_all();
    chk("tck_filt",   filt0,  m_filt);    chk("tck_filt_h",  filt1,  m_filt);
    chk("rise_vld",   rvld0,  m_rvld);    chk("rise_vld_h",  rvld1,  m_rvld);
    chk("fall_vld",   fvld0,  m_fvld);    chk("fall_vld_h",  fvld1,  m_fvld);
    chk("rise_data",  rdata0, m_rd0);     chk("rise_data_h", rdata1, m_rd1);
    chk("fall_data",  fdata0, m_fd0);     chk("fall_data_h", fdata1, m_fd1);
    chk("rise_cnt",   cnt0,   m_cnt);     chk("rise_cnt_h",  cnt1,   m_cnt);
    chk("overrun",    ovr0,   m_ovr);     chk("overrun_h",   ovr1,   m_ovr);
    if (prev_cnt == 8'hFF && cnt0 == 8'h00) saw_wrap = 1;
    prev_cnt = cnt0;
  endtask

  task automatic cycle(input bit t, input logic [3:0] r, input logic f,
                       input bit e, input bit c);
    tck = t; rch = r; fch = f; en = e; clr = c;
    @(posedge clk);
    if (rst_n) model_step(t, r, f, e, c);
    #1;
    compare_all();
  endtask

  logic [3:0] cur_r;
  logic       cur_f;
  bit         cur_t, cur_e, fall_first, any_rise, seen;
  logic [7:0] saved_cnt;
  int         len;

  task automatic rand_halves(input int nh);
    for (int h = 0; h < nh; h++) begin
      cur_t = !cur_t;
      if (cur_t) cur_f = !cur_f; else cur_r = 4'($urandom);
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : $urandom_range(3, 12);
      cur_e = ($urandom_range(0, 15) != 0);
      for (int k = 0; k < len; k++)
        cycle(cur_t, cur_r, cur_f, cur_e, $urandom_range(0, 7) == 0);
    end
  endtask

  initial begin
    rst_n = 0; tck = 1; en = 1; clr = 0; rch = 0; fch = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // TCK high through reset release: primes high with no rise
    for (int i = 0; i < 8; i++) begin
      cycle(1, 4'h0, 1'b0, 1, 0);
      chk("prime_no_rise", rvld0, 1'b0);
      if (i == 3) chk("prime_filt", filt0, 1'b1);
    end

    // 16-cycle TCK period with rise channel A
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 8; k++) cycle(0, 4'hA, 1'b0, 1, 0);
      for (int k = 0; k < 8; k++) begin
        cycle(1, 4'hA, 1'b0, 1, 0);
        chk("per_rise_lat", rvld0, k == 3);
        if (k == 3) chk("per_rise_data", rdata0, 4'hA);
        if (k == 4) begin
          chk("per_data_zero", rdata0, 4'h0);
          chk("per_data_hold", rdata1, 4'hA);
        end
        chk("per_no_ovr", ovr0, 1'b0);
      end
    end

    // glitches and overrun
    for (int k = 0; k < 10; k++) cycle(0, 4'h3, 1'b0, 1, 0);
    cycle(1, 4'h3, 1'b0, 1, 0);
    for (int k = 0; k < 10; k++) begin
      cycle(0, 4'h3, 1'b0, 1, 0);
      chk("glitch_filt", filt0, 1'b0);
      chk("glitch_rise", rvld0, 1'b0);
    end
    cycle(1, 4'h5, 1'b0, 1, 0); cycle(1, 4'h5, 1'b0, 1, 0);
    for (int k = 0; k < 8; k++) cycle(0, 4'h5, 1'b0, 1, 0);
    chk("ovr_set", ovr0, 1'b1);
    cycle(0, 4'h5, 1'b0, 1, 1);
    chk("ovr_clr", ovr0, 1'b0);
    for (int k = 0; k < 6; k++) cycle(0, 4'h5, 1'b0, 1, 0);
    cycle(1, 4'h6, 1'b0, 1, 0); cycle(1, 4'h6, 1'b0, 1, 0);
    for (int k = 0; k < 8; k++) begin
      cycle(0, 4'h6, 1'b0, 1, k == 3);
      if (k == 3) chk("ovr_set_wins", ovr0, 1'b1);
    end
    cycle(0, 4'h6, 1'b0, 1, 1);

    // en low for three periods, then re-enable while TCK is high
    saved_cnt = cnt0;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 8; k++) cycle(1, 4'h9, 1'b1, 0, 0);
      for (int k = 0; k < 8; k++) cycle(0, 4'h9, 1'b0, 0, 0);
    end
    chk("en_cnt_frozen", cnt0, saved_cnt);
    seen = 0; fall_first = 0; any_rise = 0;
    for (int k = 0; k < 16; k++) begin
      cycle(k < 8, 4'h9, 1'b1, k >= 5, 0);
      if (rvld0) any_rise = 1;
      if (!seen && (rvld0 || fvld0)) begin seen = 1; fall_first = fvld0; end
    end
    chk("reen_fall_first", fall_first, 1'b1);
    chk("reen_no_rise", any_rise, 1'b0);

    // randomized traffic, long enough for the rise counter to wrap
    cur_t = 0; cur_r = 0; cur_f = 0; cur_e = 1;
    rand_halves(900);
    chk("cnt_wrapped", saw_wrap, 1'b1);

    // reset in the middle of a high phase clears everything at once
    for (int k = 0; k < 6; k++) cycle(1, 4'hC, 1'b1, 1, 0);
    #2 rst_n = 0;
    #1;
    chk("rst_filt", filt1, 1'b0); chk("rst_cnt", cnt1, 8'h00);
    chk("rst_rdata", rdata1, 4'h0); chk("rst_fdata", fdata1, 1'b0);
    chk("rst_ovr", ovr0, 1'b0);
    model_reset();
    prev_cnt = 0;
    for (int k = 0; k < 3; k++) cycle(1, 4'hC, 1'b1, 1, 0);
    rst_n = 1;
    cur_t = 1;
    rand_halves(120);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
